// File: rtl/wb_window_if.sv
// Pixel-stream / window bus for wb_window: raw Bayer pixels and gains in,
// white-balanced 2x2 window with parity and strobes out.
interface wb_window_if;
  logic       frame_start;
  logic       pixel_valid;
  logic [7:0] pixel_in;
  logic [7:0] gain_r;
  logic [7:0] gain_g;
  logic [7:0] gain_b;

  logic [7:0] wb_1;
  logic [7:0] wb_2;
  logic [7:0] wb_3;
  logic [7:0] wb_4;
  logic       row;
  logic       col;
  logic       window_valid;
  logic       frame_done;

  // Source side: drives pixels and gains, consumes windows.
  modport master (
    output frame_start, pixel_valid, pixel_in, gain_r, gain_g, gain_b,
    input  wb_1, wb_2, wb_3, wb_4, row, col, window_valid, frame_done
  );

  // Block side.
  modport slave (
    input  frame_start, pixel_valid, pixel_in, gain_r, gain_g, gain_b,
    output wb_1, wb_2, wb_3, wb_4, row, col, window_valid, frame_done
  );
endinterface

// File: rtl/wb_window.sv
// Bayer RGGB white-balance gain plus one-line buffer producing a sliding 2x2
// window with top-left parity. Optional gain stage: define WB_GAIN_EN.
module wb_window #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        n_rst,
  wb_window_if.slave  bus
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    CH_R,
    CH_G,
    CH_B
  } channel_e;

  // Coordinate counters: position of the next accepted pixel.
  logic [CW-1:0] r_c_cnt;
  logic [RW-1:0] r_r_cnt;

  logic [CW-1:0] w_cur_c;
  logic [RW-1:0] w_cur_r;
  logic [CW-1:0] w_nxt_c;
  logic [RW-1:0] w_nxt_r;
  channel_e      w_ch;
  logic [7:0]    w_pix;

  // Stage 1 registers.
  logic          r_s1_valid;
  logic [7:0]    r_s1_pix;
  logic [CW-1:0] r_s1_c;
  logic [RW-1:0] r_s1_r;

  // Stage 2 storage and outputs.
  logic [7:0]    r_line_buf [IMG_WIDTH];
  logic [7:0]    w_top;
  logic [7:0]    r_top_hold;
  logic [7:0]    r_bot_hold;
  logic [7:0]    r_wb_1;
  logic [7:0]    r_wb_2;
  logic [7:0]    r_wb_3;
  logic [7:0]    r_wb_4;
  logic          r_row;
  logic          r_col;
  logic          r_window_valid;
  logic          r_frame_done;

  // NOTE: every signal gets a default at the top of always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_cur_c = r_c_cnt;
    w_cur_r = r_r_cnt;
    if (bus.frame_start) begin
      w_cur_c = '0;
      w_cur_r = '0;
    end

    w_nxt_c = w_cur_c + 1'b1;
    w_nxt_r = w_cur_r;
    if (w_cur_c == C_LAST) begin
      w_nxt_c = '0;
      w_nxt_r = (w_cur_r == R_LAST) ? '0 : w_cur_r + 1'b1;
    end

    w_ch = CH_G;
    if (!w_cur_r[0] && !w_cur_c[0]) begin
      w_ch = CH_R;
    end else if (w_cur_r[0] && w_cur_c[0]) begin
      w_ch = CH_B;
    end
  end

`ifdef WB_GAIN_EN
  logic [7:0]  w_gain;
  logic [15:0] w_prod;
  logic [9:0]  w_scaled;

  always_comb begin
    w_gain = bus.gain_g;
    case (w_ch)
      CH_R:    w_gain = bus.gain_r;
      CH_B:    w_gain = bus.gain_b;
      default: w_gain = bus.gain_g;
    endcase
    // Q2.6 gain: drop the 6 fraction bits, then clamp anything above 255.
    w_prod   = 16'(bus.pixel_in) * 16'(w_gain);
    w_scaled = w_prod[15:6];
    w_pix    = (w_scaled[9:8] != 2'b00) ? 8'hFF : w_scaled[7:0];
  end
`else
  logic w_unused_gain;

  assign w_pix         = bus.pixel_in;
  assign w_unused_gain = ^{bus.gain_r, bus.gain_g, bus.gain_b, w_ch};
`endif

  // Previous line's pixel in the column currently leaving stage 1.
  assign w_top = r_line_buf[r_s1_c];

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_c_cnt        <= '0;
      r_r_cnt        <= '0;
      r_s1_valid     <= 1'b0;
      r_s1_pix       <= '0;
      r_s1_c         <= '0;
      r_s1_r         <= '0;
      r_top_hold     <= '0;
      r_bot_hold     <= '0;
      r_wb_1         <= '0;
      r_wb_2         <= '0;
      r_wb_3         <= '0;
      r_wb_4         <= '0;
      r_row          <= 1'b0;
      r_col          <= 1'b0;
      r_window_valid <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      if (bus.pixel_valid) begin
        r_c_cnt <= w_nxt_c;
        r_r_cnt <= w_nxt_r;
      end else if (bus.frame_start) begin
        r_c_cnt <= '0;
        r_r_cnt <= '0;
      end

      r_s1_valid <= bus.pixel_valid;
      if (bus.pixel_valid) begin
        r_s1_pix <= w_pix;
        r_s1_c   <= w_cur_c;
        r_s1_r   <= w_cur_r;
      end

      r_window_valid <= 1'b0;
      r_frame_done   <= 1'b0;
      if (r_s1_valid) begin
        r_top_hold <= w_top;
        r_bot_hold <= r_s1_pix;
        // Row 0 and column 0 only prime the buffer and hold registers.
        if ((r_s1_r != '0) && (r_s1_c != '0)) begin
          r_wb_1         <= r_top_hold;
          r_wb_2         <= w_top;
          r_wb_3         <= r_bot_hold;
          r_wb_4         <= r_s1_pix;
          r_row          <= ~r_s1_r[0];
          r_col          <= ~r_s1_c[0];
          r_window_valid <= 1'b1;
          r_frame_done   <= (r_s1_r == R_LAST) && (r_s1_c == C_LAST);
        end
      end
    end
  end

  // NOTE: the line buffer has no reset; row 0 overwrites every entry before
  // any window can read it, so clearing it would only cost a reset fan-out.
  always_ff @(posedge clk) begin
    if (r_s1_valid) begin
      r_line_buf[r_s1_c] <= r_s1_pix;
    end
  end

  assign bus.wb_1         = r_wb_1;
  assign bus.wb_2         = r_wb_2;
  assign bus.wb_3         = r_wb_3;
  assign bus.wb_4         = r_wb_4;
  assign bus.row          = r_row;
  assign bus.col          = r_col;
  assign bus.window_valid = r_window_valid;
  assign bus.frame_done   = r_frame_done;

endmodule
